// File: rtl/game_ctrl_pkg.sv
// rtl/game_ctrl_pkg.sv - shared types, constants and A/B scoring helper for the bulls-and-cows sequencer
package game_types;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_SET_D3      = 4'd1,
        S_SET_D2      = 4'd2,
        S_SET_D1      = 4'd3,
        S_SET_D0      = 4'd4,
        S_GUESS_D3    = 4'd5,
        S_GUESS_D2    = 4'd6,
        S_GUESS_D1    = 4'd7,
        S_GUESS_D0    = 4'd8,
        S_SHOW_RESULT = 4'd9,
        S_WIN         = 4'd10,
        S_LOSE        = 4'd11
    } state_t;

    localparam int         NUM_DIGITS  = 4;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    localparam digits_t DIGITS_BLANK = {NUM_DIGITS{DIGIT_BLANK}};

    // Returns {a[2:0], b[2:0]}; relies on digits within each entry being distinct.
    function automatic logic [5:0] ab_count(input digits_t target, input digits_t guess);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'd0;
        b = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (guess[2'(i)] == target[2'(j)]) begin
                    if (i == j) a = a + 3'd1;
                    else        b = b + 3'd1;
                end
            end
        end
        return {a, b};
    endfunction

    function automatic logic [1:0] slot_of(input state_t s);
        case (s)
            S_SET_D3, S_GUESS_D3: return 2'd3;
            S_SET_D2, S_GUESS_D2: return 2'd2;
            S_SET_D1, S_GUESS_D1: return 2'd1;
            default:              return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - key/switch inputs and display-facing outputs of the game sequencer
interface game_ctrl_if;
    import game_types::*;

    logic       key_ok_n;
    logic       key_back_n;
    logic [3:0] sw;
    state_t     state;
    logic       blink_on;
    digits_t    target;
    digits_t    guess;
    logic [3:0] candidate;
    logic       sw_valid;
    logic [2:0] chances;
    logic [2:0] a_cnt;
    logic [2:0] b_cnt;

    modport master (
        output key_ok_n, key_back_n, sw,
        input  state, blink_on, target, guess, candidate, sw_valid, chances, a_cnt, b_cnt
    );

    modport slave (
        input  key_ok_n, key_back_n, sw,
        output state, blink_on, target, guess, candidate, sw_valid, chances, a_cnt, b_cnt
    );

endinterface

// File: rtl/game_ctrl_key_edge.sv
// rtl/game_ctrl_key_edge.sv - one-cycle pulse on the press (1->0) edge of an active-low key level
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    logic level_q;

    // Primed as released so that leaving reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!rst_n) level_q <= 1'b1;
        else        level_q <= key_n;
    end

    assign pulse = level_q & ~key_n;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - bulls-and-cows game sequencer: entry, scoring, chances and blink timing
module game_ctrl
    import game_types::*;
#(
    parameter int BLINK_DIV   = 12_500_000,
    parameter int MAX_CHANCES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    game_ctrl_if.slave  bus
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    logic ok_p;
    logic back_raw;
    logic back_p;

    key_edge u_ok_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_ok_n),
        .pulse (ok_p)
    );

    key_edge u_back_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_back_n),
        .pulse (back_raw)
    );

    assign back_p = back_raw & ~ok_p;

    state_t           state_q,   state_d;
    digits_t          target_q,  target_d;
    digits_t          guess_q,   guess_d;
    logic [2:0]       chances_q, chances_d;
    logic [2:0]       a_cnt_q,   a_cnt_d;
    logic [2:0]       b_cnt_q,   b_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q,   blink_d;

    logic       in_set;
    logic       in_guess;
    logic [1:0] slot;
    digits_t    entry;
    logic [3:0] sw;
    logic       sw_valid;

    assign sw = bus.sw;

    // Only slots above the active one can already hold a latched digit.
    always_comb begin
        in_set   = state_q inside {S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0};
        in_guess = state_q inside {S_GUESS_D3, S_GUESS_D2, S_GUESS_D1, S_GUESS_D0};
        slot     = slot_of(state_q);
        entry    = in_set ? target_q : guess_q;
        sw_valid = (in_set || in_guess) && (sw <= DIGIT_MAX);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i > int'(slot)) && (entry[2'(i)] == sw)) sw_valid = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        guess_d     = guess_q;
        chances_d   = chances_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        case (state_q)
            S_IDLE: begin
                if (ok_p) begin
                    state_d   = S_SET_D3;
                    target_d  = DIGITS_BLANK;
                    guess_d   = DIGITS_BLANK;
                    chances_d = 3'(MAX_CHANCES);
                end
            end

            S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0: begin
                if (ok_p) begin
                    if (sw_valid) begin
                        target_d[slot] = sw;
                        state_d        = state_t'(state_q + 4'd1);
                        if (slot == 2'd0) guess_d = DIGITS_BLANK;
                    end
                end else if (back_p && (slot != 2'd3)) begin
                    state_d                = state_t'(state_q - 4'd1);
                    target_d[slot + 2'd1]  = DIGIT_BLANK;
                end
            end

            S_GUESS_D3, S_GUESS_D2, S_GUESS_D1, S_GUESS_D0: begin
                if (ok_p) begin
                    if (sw_valid) begin
                        guess_d[slot] = sw;
                        state_d       = state_t'(state_q + 4'd1);
                        if (slot == 2'd0) begin
                            {a_cnt_d, b_cnt_d} = ab_count(target_q, guess_d);
                            if (chances_q != 3'd0) chances_d = chances_q - 3'd1;
                        end
                    end
                end else if (back_p && (slot != 2'd3)) begin
                    state_d               = state_t'(state_q - 4'd1);
                    guess_d[slot + 2'd1]  = DIGIT_BLANK;
                end
            end

            S_SHOW_RESULT: begin
                if (ok_p) begin
                    if (a_cnt_q == 3'd4) begin
                        state_d = S_WIN;
                    end else if (chances_q == 3'd0) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_GUESS_D3;
                        guess_d = DIGITS_BLANK;
                    end
                end
            end

            S_WIN, S_LOSE: begin
                if (ok_p) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Restart the blink phase on any state change so the new digit is lit at once.
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            target_q    <= DIGITS_BLANK;
            guess_q     <= DIGITS_BLANK;
            chances_q   <= 3'd0;
            a_cnt_q     <= 3'd0;
            b_cnt_q     <= 3'd0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            guess_q     <= guess_d;
            chances_q   <= chances_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.blink_on  = blink_q;
    assign bus.target    = target_q;
    assign bus.guess     = guess_q;
    assign bus.candidate = sw;
    assign bus.sw_valid  = sw_valid;
    assign bus.chances   = chances_q;
    assign bus.a_cnt     = a_cnt_q;
    assign bus.b_cnt     = b_cnt_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl with directed key/switch sequences
module tb_game_ctrl;
    import game_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(.BLINK_DIV(4), .MAX_CHANCES(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        state_t     st;
        logic [2:0] ch;
        logic [2:0] a;
        logic [2:0] b;
        digits_t    tgt;
        digits_t    gss;
    } rec_t;

    rec_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    state_t     last_st;
    state_t     e_st;
    logic [2:0] e_ch, e_a, e_b, nxt_a, nxt_b;
    digits_t    e_tgt, e_gss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push();
        exp_q.push_back('{e_st, e_ch, e_a, e_b, e_tgt, e_gss});
    endtask

    // Monitor: every state change the DUT presents is matched against the next expected record.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && (bus.state !== last_st)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_state_change", bus.state, last_st);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("state",   bus.state,   r.st);
                    chk("chances", bus.chances, r.ch);
                    chk("a_cnt",   bus.a_cnt,   r.a);
                    chk("b_cnt",   bus.b_cnt,   r.b);
                    chk("target",  bus.target,  r.tgt);
                    chk("guess",   bus.guess,   r.gss);
                    chk("blink_on_at_change", bus.blink_on, 1);
                end
            end
            last_st = bus.state;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic state_t next_of(input state_t s);
        case (s)
            S_SET_D3:   return S_SET_D2;
            S_SET_D2:   return S_SET_D1;
            S_SET_D1:   return S_SET_D0;
            S_SET_D0:   return S_GUESS_D3;
            S_GUESS_D3: return S_GUESS_D2;
            S_GUESS_D2: return S_GUESS_D1;
            S_GUESS_D1: return S_GUESS_D0;
            S_GUESS_D0: return S_SHOW_RESULT;
            default:    return s;
        endcase
    endfunction

    function automatic int slot_idx(input state_t s);
        case (s)
            S_SET_D3, S_GUESS_D3: return 3;
            S_SET_D2, S_GUESS_D2: return 2;
            S_SET_D1, S_GUESS_D1: return 1;
            default:              return 0;
        endcase
    endfunction

    task automatic press(input bit ok, input bit back, input logic [3:0] v, input bit chg);
        @(negedge clk);
        bus.sw         = v;
        bus.key_ok_n   = !ok;
        bus.key_back_n = !back;
        if (chg) push();
        @(negedge clk);
        bus.key_ok_n   = 1'b1;
        bus.key_back_n = 1'b1;
    endtask

    task automatic ok_digit(input logic [3:0] v, input bit with_back);
        int s;
        s = slot_idx(e_st);
        if (e_st inside {S_SET_D3, S_SET_D2, S_SET_D1, S_SET_D0}) begin
            e_tgt[s[1:0]] = v;
            if (s == 0) e_gss = DIGITS_BLANK;
        end else begin
            e_gss[s[1:0]] = v;
            if (s == 0) begin
                e_ch = e_ch - 3'd1;
                e_a  = nxt_a;
                e_b  = nxt_b;
            end
        end
        e_st = next_of(e_st);
        press(1'b1, with_back, v, 1'b1);
    endtask

    task automatic enter4(input logic [3:0] d3, d2, d1, d0, input logic [2:0] a, b);
        nxt_a = a;
        nxt_b = b;
        ok_digit(d3, 1'b0);
        ok_digit(d2, 1'b0);
        ok_digit(d1, 1'b0);
        ok_digit(d0, 1'b0);
    endtask

    task automatic ok_to(input state_t ns);
        e_st = ns;
        press(1'b1, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic new_game();
        e_tgt = DIGITS_BLANK;
        e_gss = DIGITS_BLANK;
        e_ch  = 3'd5;
        ok_to(S_SET_D3);
    endtask

    task automatic next_round();
        e_gss = DIGITS_BLANK;
        ok_to(S_GUESS_D3);
    endtask

    initial begin
        bus.key_ok_n   = 1'b1;
        bus.key_back_n = 1'b1;
        bus.sw         = 4'd1;
        e_st = S_IDLE; e_ch = 3'd0; e_a = 3'd0; e_b = 3'd0;
        e_tgt = DIGITS_BLANK; e_gss = DIGITS_BLANK;
        nxt_a = 3'd0; nxt_b = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_state",    bus.state,    S_IDLE);
        chk("rst_chances",  bus.chances,  0);
        chk("rst_target",   bus.target,   16'hFFFF);
        chk("rst_guess",    bus.guess,    16'hFFFF);
        chk("rst_ab",       {bus.a_cnt, bus.b_cnt}, 0);
        chk("rst_blink",    bus.blink_on, 1);
        chk("idle_sw_valid", bus.sw_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);

        // Full entry and win path
        new_game();
        enter4(4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4, 3'd4, 3'd0);
        ok_to(S_WIN);
        ok_to(S_IDLE);

        // Feedback patterns, then run out of chances
        new_game();
        enter4(4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0);
        enter4(4'd4, 4'd3, 4'd2, 4'd1, 3'd0, 3'd4);
        next_round();
        enter4(4'd1, 4'd3, 4'd2, 4'd5, 3'd1, 3'd2);
        next_round();
        enter4(4'd5, 4'd6, 4'd7, 4'd8, 3'd0, 3'd0);
        next_round();
        enter4(4'd5, 4'd6, 4'd7, 4'd8, 3'd0, 3'd0);
        next_round();
        enter4(4'd5, 4'd6, 4'd7, 4'd8, 3'd0, 3'd0);
        chk("chances_zero", bus.chances, 0);
        ok_to(S_LOSE);
        ok_to(S_IDLE);

        // Validity and back during target entry
        new_game();
        ok_digit(4'd7, 1'b0);
        @(negedge clk); bus.sw = 4'd7; #1;
        chk("sw_valid_dup", bus.sw_valid, 0);
        chk("candidate", bus.candidate, 4'd7);
        press(1'b1, 1'b0, 4'd7, 1'b0);
        @(negedge clk); bus.sw = 4'hA; #1;
        chk("sw_valid_hex", bus.sw_valid, 0);
        @(negedge clk); bus.sw = 4'd0; #1;
        chk("sw_valid_zero", bus.sw_valid, 1);
        ok_digit(4'd0, 1'b0);
        e_tgt[2] = DIGIT_BLANK; e_st = S_SET_D2;
        press(1'b0, 1'b1, 4'd0, 1'b1);
        ok_digit(4'd0, 1'b0);
        ok_digit(4'd9, 1'b0);
        ok_digit(4'd5, 1'b0);

        // Five wrong guesses with back and ok+back inside the first
        press(1'b0, 1'b1, 4'd0, 1'b0);
        nxt_a = 3'd0; nxt_b = 3'd0;
        ok_digit(4'd1, 1'b0);
        ok_digit(4'd2, 1'b0);
        e_gss[2] = DIGIT_BLANK; e_st = S_GUESS_D2;
        press(1'b0, 1'b1, 4'd0, 1'b1);
        ok_digit(4'd3, 1'b1);
        ok_digit(4'd4, 1'b0);
        ok_digit(4'd6, 1'b0);
        press(1'b0, 1'b1, 4'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            next_round();
            enter4(4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0);
        end
        ok_to(S_LOSE);
        ok_to(S_IDLE);

        // Blink period and restart on a state change
        chk("blink_k0", bus.blink_on, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("blink_run", bus.blink_on, (k < 4) ? 1 : 0);
        end
        new_game();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("blink_restart", bus.blink_on, (k < 4) ? 1 : 0);
        end

        // Reset in the middle of guess entry
        enter4(4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0);
        ok_digit(4'd5, 1'b0);
        ok_digit(4'd6, 1'b0);
        @(negedge clk);
        e_st = S_IDLE; e_ch = 3'd0; e_a = 3'd0; e_b = 3'd0;
        e_tgt = DIGITS_BLANK; e_gss = DIGITS_BLANK;
        push();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
